aes_blok_toplayici: RTL and testbench

- Upstream feeder for aes_engine: packs a byte stream into 128-bit plaintext blocks, applies PKCS#7 padding at message end, and buffers completed blocks in a small FIFO.
- Issues one block at a time to the engine's blok/g_gecerli inputs, gated by the engine's hazir output and a minimum issue spacing.
- Sits between the byte source (UART/host bus) and aes_engine.

---
 rtl/aes_blok_toplayici_if.sv | 24 ++
 rtl/aes_blok_toplayici.sv | 87 ++++++++
 tb/tb_aes_blok_toplayici.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/aes_blok_toplayici_if.sv
// Byte-stream input and engine-side block handshake of the AES block feeder.
// The master side is the byte source and engine; the slave side is the feeder.
interface aes_blok_toplayici_if #(
  parameter int DERINLIK = 4
);
  logic [7:0]                  bayt;
  logic                        bayt_gecerli;
  logic                        son;
  logic                        bayt_hazir;
  logic                        hazir;
  logic [127:0]                blok;
  logic                        g_gecerli;
  logic [$clog2(DERINLIK):0]   doluluk;

  modport master (
    output bayt, bayt_gecerli, son, hazir,
    input  bayt_hazir, blok, g_gecerli, doluluk
  );

  modport slave (
    input  bayt, bayt_gecerli, son, hazir,
    output bayt_hazir, blok, g_gecerli, doluluk
  );
endinterface

// File: rtl/aes_blok_toplayici.sv
// Packs bytes into 128-bit blocks with PKCS#7 padding, queues them in a small
// FIFO and issues them to the AES engine with a minimum spacing between strobes.
module aes_blok_toplayici #(
  parameter int DERINLIK   = 4,
  parameter int MIN_ARALIK = 11
) (
  input logic                  clk,
  input logic                  rst,
  aes_blok_toplayici_if.slave  bus
);
  localparam int AW = $clog2(DERINLIK);
  localparam int CW = (MIN_ARALIK > 1) ? $clog2(MIN_ARALIK) : 1;
  localparam logic [AW:0]   DOLU_SAYI  = DERINLIK[AW:0];
  localparam logic [CW-1:0] ARALIK_YUK = CW'(MIN_ARALIK - 1);

  typedef enum logic {TOPLA, EK_BLOK} durum_t;

  durum_t           durum;
  logic [15:0][7:0] paket, yeni_blok;
  logic [127:0]     push_veri;
  logic [3:0]       indeks;
  logic [127:0]     mem [DERINLIK];
  logic [AW-1:0]    yaz_ptr, oku_ptr;
  logic [AW:0]      doluluk;
  logic [CW-1:0]    aralik;
  logic             dolu, kabul, ek_push, push, pop;

  assign dolu           = (doluluk == DOLU_SAYI);
  assign bus.bayt_hazir = rst && (durum == TOPLA) && !dolu;
  assign bus.doluluk    = doluluk;
  assign kabul          = bus.bayt_gecerli && bus.bayt_hazir;
  assign ek_push        = (durum == EK_BLOK) && !dolu;
  assign push           = (kabul && ((indeks == 4'd15) || bus.son)) || ek_push;
  assign pop            = (doluluk != '0) && bus.hazir && (aralik == '0);
  assign push_veri      = ek_push ? {16{8'h10}} : yeni_blok;

  // Byte k lands in element 15-k so the first byte ends up in [127:120].
  always_comb begin
    yeni_blok = paket;
    yeni_blok[4'd15 - indeks] = bus.bayt;
    if (bus.son) begin
      for (int j = 0; j < 16; j++) begin
        if (4'(j) > indeks) yeni_blok[15-j] = 8'(4'd15 - indeks);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[yaz_ptr] <= push_veri;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      durum         <= TOPLA;
      paket         <= '0;
      indeks        <= '0;
      yaz_ptr       <= '0;
      oku_ptr       <= '0;
      doluluk       <= '0;
      aralik        <= '0;
      bus.blok      <= '0;
      bus.g_gecerli <= 1'b0;
    end else begin
      if (kabul) begin
        paket  <= yeni_blok;
        indeks <= ((indeks == 4'd15) || bus.son) ? 4'd0 : indeks + 4'd1;
      end
      // A message ending exactly on a block boundary still owes a full pad block.
      if (kabul && bus.son && (indeks == 4'd15)) durum <= EK_BLOK;
      else if (ek_push)                          durum <= TOPLA;

      if (push) yaz_ptr <= yaz_ptr + 1'b1;
      if (pop)  oku_ptr <= oku_ptr + 1'b1;
      case ({push, pop})
        2'b10:   doluluk <= doluluk + 1'b1;
        2'b01:   doluluk <= doluluk - 1'b1;
        default: doluluk <= doluluk;
      endcase

      if (pop)                aralik <= ARALIK_YUK;
      else if (aralik != '0)  aralik <= aralik - 1'b1;

      bus.g_gecerli <= pop;
      if (pop) bus.blok <= mem[oku_ptr];
    end
  end
endmodule

// File: tb/tb_aes_blok_toplayici.sv
// Directed bench: a byte-level model builds expected blocks into a scoreboard
// queue; a monitor pops and compares on every issue strobe.
module tb_aes_blok_toplayici;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  aes_blok_toplayici_if #(.DERINLIK(4)) bus ();
  aes_blok_toplayici #(.DERINLIK(4), .MIN_ARALIK(11)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0, n_pass = 0, cyc = 0, n_issue = 0;
  logic [127:0] sb[$];
  int           issue_cyc[$];
  logic [7:0]   msg[$];
  logic [127:0] last_blok = '0;
  logic         prev_g = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Monitor: order via scoreboard, 1-cycle strobe width, blok stable between strobes.
  always @(negedge clk) begin
    logic [127:0] e;
    if (!rst) begin
      last_blok = '0;
      prev_g    = 1'b0;
    end else begin
      if (bus.g_gecerli) begin
        e = (sb.size() != 0) ? sb.pop_front() : 'x;
        chk("issue_blok", bus.blok, e);
        chk("strobe_width", {127'd0, prev_g}, 128'd0);
        issue_cyc.push_back(cyc);
        n_issue++;
        last_blok = bus.blok;
      end else begin
        chk("blok_stable", bus.blok, last_blok);
      end
      prev_g = bus.g_gecerli;
    end
  end

  task automatic expect_msg(input bit with_son);
    logic [127:0] b;
    int r;
    for (int i = 0; i + 16 <= msg.size(); i += 16) begin
      b = '0;
      for (int j = 0; j < 16; j++) b = {b[119:0], msg[i+j]};
      sb.push_back(b);
    end
    if (with_son) begin
      r = msg.size() % 16;
      b = '0;
      for (int j = 0; j < 16; j++)
        b = {b[119:0], (j < r) ? msg[msg.size()-r+j] : 8'(16 - r)};
      sb.push_back(b);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit s);
    int t = 0;
    @(negedge clk);
    bus.bayt = b; bus.bayt_gecerli = 1'b1; bus.son = s;
    while (!bus.bayt_hazir && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) chk("send_timeout", {127'd0, bus.bayt_hazir}, 128'd1);
    @(posedge clk); #1;
    bus.bayt_gecerli = 1'b0; bus.son = 1'b0;
  endtask

  task automatic send_range(input int a, input int b, input bit son_last);
    for (int i = a; i <= b; i++) send(msg[i], son_last && (i == b));
  endtask

  task automatic fill_msg(input int n);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic wait_issues(input int n);
    int t = 0;
    while (n_issue < n && t < 3000) begin @(negedge clk); t++; end
    chk("issue_count", 128'(n_issue), 128'(n));
  endtask

  initial begin
    int base, t;
    bus.bayt = '0; bus.bayt_gecerli = 1'b0; bus.son = 1'b0; bus.hazir = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_blok", bus.blok, '0);
    chk("rst_g", {127'd0, bus.g_gecerli}, 128'd0);
    chk("rst_doluluk", 128'(bus.doluluk), 128'd0);
    chk("rst_bayt_hazir", {127'd0, bus.bayt_hazir}, 128'd0);
    rst = 1'b1;

    // Message ending on a block boundary: data block then full pad block.
    bus.hazir = 1'b1;
    msg.delete();
    for (int i = 0; i < 16; i++) msg.push_back(8'(i));
    chk("model_first", {msg[0], msg[15]}, 128'h000F);
    expect_msg(1'b1);
    send_range(0, 15, 1'b1);
    wait_issues(2);
    chk("pad_spacing", 128'(issue_cyc[1] - issue_cyc[0]), 128'd11);

    // Short message padded in place.
    msg.delete();
    msg.push_back(8'hAA); msg.push_back(8'hBB); msg.push_back(8'hCC);
    sb.push_back(128'hAABBCC0D0D0D0D0D0D0D0D0D0D0D0D0D);
    send_range(0, 2, 1'b1);
    wait_issues(3);

    // Fill FIFO with engine stalled, then release.
    bus.hazir = 1'b0;
    fill_msg(80);
    expect_msg(1'b0);
    send_range(0, 63, 1'b0);
    @(negedge clk);
    chk("full_doluluk", 128'(bus.doluluk), 128'd4);
    chk("full_bayt_hazir", {127'd0, bus.bayt_hazir}, 128'd0);
    bus.hazir = 1'b1;
    @(negedge clk);
    chk("release_g", {127'd0, bus.g_gecerli}, 128'd1);
    chk("release_bayt_hazir", {127'd0, bus.bayt_hazir}, 128'd1);
    chk("release_doluluk", 128'(bus.doluluk), 128'd3);
    send_range(64, 79, 1'b0);
    wait_issues(8);

    // Back-to-back issues from a pre-filled FIFO.
    bus.hazir = 1'b0;
    fill_msg(48);
    expect_msg(1'b0);
    send_range(0, 47, 1'b0);
    base = n_issue;
    @(negedge clk);
    bus.hazir = 1'b1;
    wait_issues(base + 3);
    chk("b2b_gap0", 128'(issue_cyc[base+1] - issue_cyc[base]), 128'd11);
    chk("b2b_gap1", 128'(issue_cyc[base+2] - issue_cyc[base+1]), 128'd11);

    // Asynchronous reset mid-block with two blocks queued.
    bus.hazir = 1'b0;
    fill_msg(39);
    send_range(0, 38, 1'b0);
    chk("pre_rst_doluluk", 128'(bus.doluluk), 128'd2);
    #2 rst = 1'b0;
    sb.delete();
    #1;
    chk("arst_blok", bus.blok, '0);
    chk("arst_g", {127'd0, bus.g_gecerli}, 128'd0);
    chk("arst_doluluk", 128'(bus.doluluk), 128'd0);
    chk("arst_bayt_hazir", {127'd0, bus.bayt_hazir}, 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    base = n_issue;
    fill_msg(16);
    expect_msg(1'b0);
    bus.hazir = 1'b1;
    send_range(0, 15, 1'b0);
    wait_issues(base + 1);
    repeat (30) @(negedge clk);
    chk("post_rst_one_issue", 128'(n_issue), 128'(base + 1));
    chk("post_rst_sb_empty", 128'(sb.size()), 128'd0);

    // Full FIFO while a boundary-ending message owes its pad block.
    bus.hazir = 1'b0;
    base = n_issue;
    fill_msg(64);
    expect_msg(1'b1);
    send_range(0, 63, 1'b1);
    @(negedge clk);
    chk("ek_full_doluluk", 128'(bus.doluluk), 128'd4);
    repeat (5) @(negedge clk);
    chk("ek_wait_bayt_hazir", {127'd0, bus.bayt_hazir}, 128'd0);
    bus.hazir = 1'b1;
    @(negedge clk);
    chk("ek_pop_g", {127'd0, bus.g_gecerli}, 128'd1);
    chk("ek_pop_bayt_hazir", {127'd0, bus.bayt_hazir}, 128'd0);
    @(negedge clk);
    chk("ek_pushed_doluluk", 128'(bus.doluluk), 128'd4);
    t = 0;
    while (!bus.bayt_hazir && t < 100) begin @(negedge clk); t++; end
    chk("ek_bayt_hazir_back", {127'd0, bus.bayt_hazir}, 128'd1);
    wait_issues(base + 5);
    repeat (5) @(negedge clk);
    chk("final_sb_empty", 128'(sb.size()), 128'd0);
    chk("final_doluluk", 128'(bus.doluluk), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
